kernel_result_collector: RTL and testbench
==========================================

Name: kernel_result_collector

Overview:
- Sequencer and result sink placed directly downstream of the mapped matrix-multiply kernel.
- Generates the kernel's global enable and reset, watches the loop-exit flag from the compare unit, and lets in-flight pipeline data drain into the accumulator.
- Captures the final accumulator word and hands it to the host over a valid/ready handshake.
- Detects runaway kernels with a cycle timeout.

Parameters:
- WIDTH, 32, data width of the accumulator input and the result.
- CLEAR_CYCLES, 2, cycles `kern_rst` is held high before the run starts (≥1).
- DRAIN_CYCLES, 3, cycles `kern_en` stays high after the exit flag is seen, covering the ALU/reg pipeline depth (≥0).
- TIMEOUT_W, 16, width of the run-cycle counter; timeout fires at 2^TIMEOUT_W−1 run cycles.

Ports:
- clk  in  1  fabric clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  host pulse that begins a kernel run
- busy  out  1  high in every state except IDLE
- kern_en  out  1  drives the kernel's global enable
- kern_rst  out  1  drives the kernel's global reset (active-high, synchronous to the reg units)
- exit_flag  in  1  loop-exit flag from the kernel compare output
- acc_data  in  WIDTH  kernel accumulator output
- res_data  out  WIDTH  captured result
- res_valid  out  1  result available
- res_ready  in  1  host accepts the result
- timeout  out  1  sticky error: last run hit the cycle limit

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - All outputs are 0: busy, kern_en, kern_rst, res_data, res_valid, timeout, and the internal counters.
  - Reset asserted mid-run aborts immediately; the kernel sees kern_en=0 on the same edge.
- States: IDLE, CLEAR, RUN, DRAIN, HOLD. All outputs are registered.
- IDLE:
  - kern_en=0, kern_rst=0.
  - start=1 → CLEAR; clears timeout and the run counter.
- CLEAR:
  - kern_rst=1, kern_en=0 for exactly CLEAR_CYCLES cycles, then → RUN.
  - exit_flag is ignored here.
- RUN:
  - kern_en=1, kern_rst=0; run counter increments each cycle, saturating.
  - exit_flag=1 is sampled on any RUN cycle, including the first.
    - DRAIN_CYCLES>0 → DRAIN.
    - DRAIN_CYCLES=0 → capture acc_data, then HOLD.
  - Counter reaches all-ones with no exit → set timeout=1, capture acc_data, → HOLD.
  - exit_flag and the timeout in the same cycle: exit wins, timeout stays 0.
- DRAIN:
  - kern_en=1 for DRAIN_CYCLES cycles.
  - On the last cycle, capture acc_data into res_data, drop kern_en, → HOLD.
  - exit_flag toggling here is ignored.
- HOLD:
  - kern_en=0, res_valid=1, res_data stable.
  - res_valid & res_ready → res_valid=0, → IDLE on the next cycle.
- start:
  - Ignored in every state except IDLE, including the handshake cycle.
  - Held high continuously, it begins a new run on the first IDLE cycle.
- res_ready while res_valid=0 has no effect.
- Latency from start to the first kern_en cycle is CLEAR_CYCLES+1.
- Latency from the exit_flag sample to res_valid=1 is DRAIN_CYCLES+1.
- busy=1 in CLEAR, RUN, DRAIN and HOLD.

Optional Feature:
- Macro: KERNEL_RESULT_COLLECTOR_CYCLE_COUNT_EN.
- Defined:
  - Adds output port `run_cycles` [TIMEOUT_W-1:0], which latches the run counter value when the FSM enters HOLD.
  - The value counts RUN cycles only; DRAIN cycles are excluded.
  - Reset value is 0; it holds until the next capture.
- Undefined: the port and its register are absent; the rest of the behaviour is identical.

Decomposition:
- Shared package `cgra_ctrl_pkg` holds:
  - the state enum (IDLE, CLEAR, RUN, DRAIN, HOLD);
  - the default WIDTH constant;
  - a localparam helper for the timeout limit.
- One natural sub-module: `cycle_down_counter`, a loadable down-counter with a zero flag, instantiated for the CLEAR and DRAIN phases.
- The run counter stays inline.

Test Plan:
- CLEAR_CYCLES=2, DRAIN_CYCLES=3; start pulse; exit_flag high on run cycle 20; acc_data=0x1234 on the final drain cycle → kern_rst high for 2 cycles, kern_en high for 23 cycles, res_valid after 4 cycles, res_data=0x1234, timeout=0.
- res_ready held low 10 cycles in HOLD, then high → res_data/res_valid stable throughout; res_valid clears and busy drops the next cycle.
- TIMEOUT_W=4, exit_flag never asserted → after 15 RUN cycles timeout=1, res_valid=1 with acc_data captured, no DRAIN phase.
- rst_n pulsed low during DRAIN → kern_en, res_valid, busy go 0 immediately; a new start then runs cleanly.
- start re-pulsed during RUN and during the HOLD handshake cycle → ignored; exactly one run per accepted start.
- DRAIN_CYCLES=0, exit_flag on the first RUN cycle → result captured that cycle, res_valid the next; with the macro defined, run_cycles=1.

Source files
------------

// File: rtl/cgra_ctrl_pkg.sv
// Shared definitions for the kernel sequencing/result-collection logic:
// FSM state encoding, default data width and the run-timeout limit helper.
package cgra_ctrl_pkg;

  localparam int DEF_WIDTH     = 32;
  localparam int DEF_TIMEOUT_W = 16;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_HOLD  = 3'd4
  } ctrl_state_e;

  // All-ones value of a w-bit run counter; the run aborts when it is reached.
  function automatic longint unsigned timeout_limit(input int unsigned w);
    return (64'd1 << w) - 64'd1;
  endfunction

endpackage

// File: rtl/kernel_result_collector_if.sv
// Host/kernel-facing signal bundle of kernel_result_collector.
// run_cycles exists only when KERNEL_RESULT_COLLECTOR_CYCLE_COUNT_EN is defined.
interface kernel_result_collector_if
  import cgra_ctrl_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int TIMEOUT_W = DEF_TIMEOUT_W
) ();

  logic             start;
  logic             busy;
  logic             kern_en;
  logic             kern_rst;
  logic             exit_flag;
  logic [WIDTH-1:0] acc_data;
  logic [WIDTH-1:0] res_data;
  logic             res_valid;
  logic             res_ready;
  logic             timeout;
`ifdef KERNEL_RESULT_COLLECTOR_CYCLE_COUNT_EN
  logic [TIMEOUT_W-1:0] run_cycles;
`endif

  modport master (
    input  start, exit_flag, acc_data, res_ready,
    output busy, kern_en, kern_rst, res_data, res_valid, timeout
`ifdef KERNEL_RESULT_COLLECTOR_CYCLE_COUNT_EN
    , output run_cycles
`endif
  );

  modport slave (
    output start, exit_flag, acc_data, res_ready,
    input  busy, kern_en, kern_rst, res_data, res_valid, timeout
`ifdef KERNEL_RESULT_COLLECTOR_CYCLE_COUNT_EN
    , input run_cycles
`endif
  );

endinterface

// File: rtl/cycle_down_counter.sv
// Loadable down-counter with a zero flag; times the CLEAR and DRAIN phases.
module cycle_down_counter #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_zero
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/kernel_result_collector.sv
// Sequences the matrix-multiply kernel (clear, run, drain) and hands the final
// accumulator word to the host. KERNEL_RESULT_COLLECTOR_CYCLE_COUNT_EN adds run_cycles.
module kernel_result_collector
  import cgra_ctrl_pkg::*;
#(
  parameter int WIDTH        = DEF_WIDTH,
  parameter int CLEAR_CYCLES = 2,
  parameter int DRAIN_CYCLES = 3,
  parameter int TIMEOUT_W    = DEF_TIMEOUT_W
) (
  input logic                      clk,
  input logic                      rst_n,
  kernel_result_collector_if.master bus
);

  localparam logic [TIMEOUT_W-1:0] LP_LIMIT = TIMEOUT_W'(timeout_limit(TIMEOUT_W));
  localparam int LP_CLR_W      = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;
  localparam int LP_DRN_W      = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam int LP_DRAIN_LOAD = (DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0;

  function automatic logic [TIMEOUT_W-1:0] sat_inc(input logic [TIMEOUT_W-1:0] v);
    return (v == LP_LIMIT) ? v : v + TIMEOUT_W'(1);
  endfunction

  ctrl_state_e          r_state;
  ctrl_state_e          w_state_nxt;
  logic                 r_busy;
  logic                 r_kern_en;
  logic                 r_kern_rst;
  logic                 r_res_valid;
  logic [WIDTH-1:0]     r_res_data;
  logic                 r_timeout;
  logic [TIMEOUT_W-1:0] r_run_cnt;
  logic [TIMEOUT_W-1:0] w_run_cnt_nxt;

  logic w_clr_load, w_clr_dec, w_clr_zero;
  logic w_drn_load, w_drn_dec, w_drn_zero;
  logic w_capture, w_set_timeout, w_run_clear, w_run_inc;

  assign w_run_cnt_nxt = sat_inc(r_run_cnt);

  cycle_down_counter #(.CNT_W(LP_CLR_W)) u_clear_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_clr_load),
    .i_load_val (LP_CLR_W'(CLEAR_CYCLES - 1)),
    .i_dec      (w_clr_dec),
    .o_zero     (w_clr_zero)
  );

  cycle_down_counter #(.CNT_W(LP_DRN_W)) u_drain_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_drn_load),
    .i_load_val (LP_DRN_W'(LP_DRAIN_LOAD)),
    .i_dec      (w_drn_dec),
    .o_zero     (w_drn_zero)
  );

  always_comb begin
    w_state_nxt   = r_state;
    w_clr_load    = 1'b0;
    w_clr_dec     = 1'b0;
    w_drn_load    = 1'b0;
    w_drn_dec     = 1'b0;
    w_capture     = 1'b0;
    w_set_timeout = 1'b0;
    w_run_clear   = 1'b0;
    w_run_inc     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_state_nxt = S_CLEAR;
          w_clr_load  = 1'b1;
          w_run_clear = 1'b1;
        end
      end
      S_CLEAR: begin
        if (w_clr_zero) w_state_nxt = S_RUN;
        else            w_clr_dec   = 1'b1;
      end
      S_RUN: begin
        w_run_inc = 1'b1;
        // Exit is checked first so a simultaneous limit hit never flags timeout.
        if (bus.exit_flag) begin
          if (DRAIN_CYCLES > 0) begin
            w_state_nxt = S_DRAIN;
            w_drn_load  = 1'b1;
          end else begin
            w_state_nxt = S_HOLD;
            w_capture   = 1'b1;
          end
        end else if (w_run_cnt_nxt == LP_LIMIT) begin
          w_state_nxt   = S_HOLD;
          w_capture     = 1'b1;
          w_set_timeout = 1'b1;
        end
      end
      S_DRAIN: begin
        if (w_drn_zero) begin
          w_state_nxt = S_HOLD;
          w_capture   = 1'b1;
        end else begin
          w_drn_dec = 1'b1;
        end
      end
      S_HOLD: begin
        if (bus.res_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with r_state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_busy      <= 1'b0;
      r_kern_en   <= 1'b0;
      r_kern_rst  <= 1'b0;
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_timeout   <= 1'b0;
      r_run_cnt   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_busy      <= (w_state_nxt != S_IDLE);
      r_kern_en   <= (w_state_nxt == S_RUN) || (w_state_nxt == S_DRAIN);
      r_kern_rst  <= (w_state_nxt == S_CLEAR);
      r_res_valid <= (w_state_nxt == S_HOLD);
      if (w_capture) r_res_data <= bus.acc_data;
      if (w_run_clear)        r_timeout <= 1'b0;
      else if (w_set_timeout) r_timeout <= 1'b1;
      if (w_run_clear)    r_run_cnt <= '0;
      else if (w_run_inc) r_run_cnt <= w_run_cnt_nxt;
    end
  end

  assign bus.busy      = r_busy;
  assign bus.kern_en   = r_kern_en;
  assign bus.kern_rst  = r_kern_rst;
  assign bus.res_valid = r_res_valid;
  assign bus.res_data  = r_res_data;
  assign bus.timeout   = r_timeout;

`ifdef KERNEL_RESULT_COLLECTOR_CYCLE_COUNT_EN
  logic [TIMEOUT_W-1:0] r_run_cycles;

  // Capturing from RUN must include the current cycle; DRAIN cycles never count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run_cycles <= '0;
    end else if (w_capture) begin
      r_run_cycles <= (r_state == S_RUN) ? w_run_cnt_nxt : r_run_cnt;
    end
  end

  assign bus.run_cycles = r_run_cycles;
`endif

endmodule

// File: tb/tb_kernel_result_collector.sv
// Directed bench for kernel_result_collector across three configurations:
// drain 3 / 16-bit timer, drain 3 / 4-bit timer, and drain 0.
module tb_kernel_result_collector;

  typedef struct {
    int          sel;
    int          run_len;
    logic [31:0] acc;
    int          cap_en;
    int          restart_at;
    int          exp_rst;
    int          exp_en;
    int          exp_vcyc;
    logic        exp_to;
    int          exp_rc;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        exit_flag;
  logic        res_ready;
  logic [31:0] acc_data;
  int          sel;

  logic        o_busy, o_en, o_rst, o_valid, o_to;
  logic [31:0] o_data;
  logic [15:0] o_rc;

  int   n_cmp = 0;
  int   n_err = 0;
  vec_t tbl[8];

  always #5 clk = ~clk;

  kernel_result_collector_if #(.WIDTH(32), .TIMEOUT_W(16)) if_m ();
  kernel_result_collector_if #(.WIDTH(32), .TIMEOUT_W(4))  if_t ();
  kernel_result_collector_if #(.WIDTH(32), .TIMEOUT_W(16)) if_d ();

  kernel_result_collector #(.WIDTH(32), .CLEAR_CYCLES(2), .DRAIN_CYCLES(3), .TIMEOUT_W(16))
    u_main (.clk(clk), .rst_n(rst_n), .bus(if_m));
  kernel_result_collector #(.WIDTH(32), .CLEAR_CYCLES(2), .DRAIN_CYCLES(3), .TIMEOUT_W(4))
    u_to   (.clk(clk), .rst_n(rst_n), .bus(if_t));
  kernel_result_collector #(.WIDTH(32), .CLEAR_CYCLES(2), .DRAIN_CYCLES(0), .TIMEOUT_W(16))
    u_d0   (.clk(clk), .rst_n(rst_n), .bus(if_d));

  assign if_m.start     = start && (sel == 0);
  assign if_t.start     = start && (sel == 1);
  assign if_d.start     = start && (sel == 2);
  assign if_m.exit_flag = exit_flag;
  assign if_t.exit_flag = exit_flag;
  assign if_d.exit_flag = exit_flag;
  assign if_m.acc_data  = acc_data;
  assign if_t.acc_data  = acc_data;
  assign if_d.acc_data  = acc_data;
  assign if_m.res_ready = res_ready;
  assign if_t.res_ready = res_ready;
  assign if_d.res_ready = res_ready;

  always_comb begin
    o_busy = if_m.busy; o_en = if_m.kern_en; o_rst = if_m.kern_rst;
    o_valid = if_m.res_valid; o_to = if_m.timeout; o_data = if_m.res_data;
    o_rc = '0;
`ifdef KERNEL_RESULT_COLLECTOR_CYCLE_COUNT_EN
    o_rc = if_m.run_cycles;
`endif
    if (sel == 1) begin
      o_busy = if_t.busy; o_en = if_t.kern_en; o_rst = if_t.kern_rst;
      o_valid = if_t.res_valid; o_to = if_t.timeout; o_data = if_t.res_data;
`ifdef KERNEL_RESULT_COLLECTOR_CYCLE_COUNT_EN
      o_rc = 16'(if_t.run_cycles);
`endif
    end else if (sel == 2) begin
      o_busy = if_d.busy; o_en = if_d.kern_en; o_rst = if_d.kern_rst;
      o_valid = if_d.res_valid; o_to = if_d.timeout; o_data = if_d.res_data;
`ifdef KERNEL_RESULT_COLLECTOR_CYCLE_COUNT_EN
      o_rc = if_d.run_cycles;
`endif
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Runs one kernel pass from a start pulse up to the first res_valid cycle.
  task automatic do_run(input vec_t v, input string tag);
    int rst_cnt = 0, en_cnt = 0, first_en = -1, vcyc = -1;
    bit busy_drop = 1'b0;
    @(negedge clk);
    sel = v.sel; start = 1'b1; exit_flag = 1'b0; res_ready = 1'b0; acc_data = ~v.acc;
    for (int cyc = 1; cyc <= 400 && vcyc < 0; cyc++) begin
      @(negedge clk);
      if (o_rst) rst_cnt++;
      if (o_en) begin
        en_cnt++;
        if (first_en < 0) first_en = cyc;
      end
      if (!o_busy) busy_drop = 1'b1;
      if (o_valid) begin
        vcyc = cyc;
      end else begin
        start     = (v.restart_at != 0) && (en_cnt == v.restart_at);
        exit_flag = (v.run_len != 0) &&
                    ((en_cnt == v.run_len) || ((en_cnt > v.run_len) && en_cnt[0]));
        acc_data  = (en_cnt == v.cap_en) ? v.acc : ~v.acc;
      end
    end
    start = 1'b0; exit_flag = 1'b0;
    if (vcyc < 0) begin
      n_cmp++; n_err++;
      $display("FAIL %s_valid_wait: res_valid never rose, required within 400 cycles", tag);
    end
    chk({tag, "_kern_rst_cycles"}, rst_cnt, v.exp_rst);
    chk({tag, "_first_en_cycle"}, first_en, 3);
    chk({tag, "_kern_en_cycles"}, en_cnt, v.exp_en);
    chk({tag, "_valid_cycle"}, vcyc, v.exp_vcyc);
    chk({tag, "_busy_held"}, {31'b0, busy_drop}, 0);
    chk({tag, "_res_data"}, o_data, v.acc);
    chk({tag, "_timeout"}, {31'b0, o_to}, {31'b0, v.exp_to});
`ifdef KERNEL_RESULT_COLLECTOR_CYCLE_COUNT_EN
    chk({tag, "_run_cycles"}, {16'b0, o_rc}, v.exp_rc);
`endif
  endtask

  task automatic do_ack(input string tag);
    res_ready = 1'b1;
    @(negedge clk);
    chk({tag, "_ack_valid"}, {31'b0, o_valid}, 0);
    chk({tag, "_ack_busy"}, {31'b0, o_busy}, 0);
    res_ready = 1'b0;
    @(negedge clk);
    chk({tag, "_idle_busy"}, {31'b0, o_busy}, 0);
  endtask

  initial begin
    vec_t v;
    int   en_cnt;
    bit   hit;
    //         sel run acc            cap rs rst en vcyc to rc
    tbl[0] = '{0, 20, 32'h0000_1234, 23, 0, 2, 23, 26, 1'b0, 20};
    tbl[1] = '{0,  1, 32'hDEAD_BEEF,  4, 0, 2,  4,  7, 1'b0,  1};
    tbl[2] = '{0,  7, 32'h8000_0001, 10, 3, 2, 10, 13, 1'b0,  7};
    tbl[3] = '{1,  0, 32'h0000_ABCD, 15, 0, 2, 15, 18, 1'b1, 15};
    tbl[4] = '{2,  1, 32'hCAFE_F00D,  1, 0, 2,  1,  4, 1'b0,  1};
    tbl[5] = '{2,  9, 32'h1357_9BDF,  9, 0, 2,  9, 12, 1'b0,  9};
    tbl[6] = '{1, 15, 32'h0000_0F0F, 18, 0, 2, 18, 21, 1'b0, 15};
    tbl[7] = '{1, 14, 32'h5A5A_A5A5, 17, 0, 2, 17, 20, 1'b0, 14};

    rst_n = 1'b0; start = 1'b0; exit_flag = 1'b0; res_ready = 1'b0;
    acc_data = '0; sel = 0;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      chk($sformatf("reset_outputs_dut%0d", s),
          {26'b0, o_busy, o_en, o_rst, o_valid, o_to, |o_data}, 0);
      chk($sformatf("reset_run_cycles_dut%0d", s), {16'b0, o_rc}, 0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      do_run(tbl[i], $sformatf("row%0d", i));
      do_ack($sformatf("row%0d", i));
    end

    // Host stalls in HOLD for 10 cycles, then start pulses in the handshake cycle.
    v = '{0, 3, 32'h0BAD_F00D, 6, 0, 2, 6, 9, 1'b0, 3};
    do_run(v, "stall");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("stall%0d_valid", i), {31'b0, o_valid}, 1);
      chk($sformatf("stall%0d_data", i), o_data, 32'h0BAD_F00D);
    end
    res_ready = 1'b1; start = 1'b1;
    @(negedge clk);
    chk("stall_ack_valid", {31'b0, o_valid}, 0);
    chk("stall_ack_busy", {31'b0, o_busy}, 0);
    res_ready = 1'b0; start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("handshake_start_ignored%0d", i), {30'b0, o_busy, o_rst}, 0);
    end

    // start held across the handshake launches a run on the first IDLE cycle;
    // exit_flag held from CLEAR onward is only honoured on the first RUN cycle.
    v = '{0, 5, 32'h7777_0001, 8, 0, 2, 8, 11, 1'b0, 5};
    do_run(v, "held");
    res_ready = 1'b1; start = 1'b1;
    @(negedge clk);
    chk("held_ack_valid", {31'b0, o_valid}, 0);
    res_ready = 1'b0;
    @(negedge clk);
    chk("held_restart", {30'b0, o_busy, o_rst}, 32'h3);
    start = 1'b0; exit_flag = 1'b1; acc_data = 32'h2468_ACE0;
    en_cnt = 0; hit = 1'b0;
    for (int c = 0; c < 50 && !hit; c++) begin
      @(negedge clk);
      if (o_en) en_cnt++;
      if (o_valid) hit = 1'b1;
    end
    exit_flag = 1'b0;
    chk("held_valid_seen", {31'b0, hit}, 1);
    chk("held_kern_en_cycles", en_cnt, 4);
    chk("held_res_data", o_data, 32'h2468_ACE0);
`ifdef KERNEL_RESULT_COLLECTOR_CYCLE_COUNT_EN
    chk("held_run_cycles", {16'b0, o_rc}, 1);
`endif
    do_ack("held");

    // Asynchronous reset in the middle of DRAIN.
    @(negedge clk);
    sel = 0; start = 1'b1; exit_flag = 1'b0; acc_data = 32'h1111_2222;
    en_cnt = 0; hit = 1'b0;
    for (int c = 0; c < 100 && !hit; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (o_en) en_cnt++;
      exit_flag = (en_cnt == 2);
      if (en_cnt == 4) hit = 1'b1;
    end
    chk("drain_reached", {31'b0, hit}, 1);
    chk("drain_en_before_reset", {31'b0, o_en}, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_reset_outputs", {27'b0, o_busy, o_en, o_rst, o_valid, o_to}, 0);
    chk("mid_reset_res_data", o_data, 0);
    @(negedge clk);
    rst_n = 1'b1; exit_flag = 1'b0;
    do_run(tbl[0], "post_reset");
    do_ack("post_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
